// File: rtl/rv32i_pkg.sv
// Shared RV32I control definitions: opcodes, ALU/RFWD encodings, FSM states, decode bundle.
// ILLEGAL_INSTR_TRAP_EN adds the HALT state used for unknown opcodes.
package rv32i_pkg;

    localparam int unsigned OPC_W  = 7;
    localparam int unsigned ALU_W  = 4;
    localparam int unsigned RFWD_W = 3;
    localparam int unsigned WAIT_W = 8;

    localparam logic [OPC_W-1:0] OPC_R      = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_I      = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;

    localparam logic [ALU_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_SRA = 4'b1101;

    localparam logic [RFWD_W-1:0] RFWD_ALU    = 3'b000;
    localparam logic [RFWD_W-1:0] RFWD_MEM    = 3'b001;
    localparam logic [RFWD_W-1:0] RFWD_IMM    = 3'b010;
    localparam logic [RFWD_W-1:0] RFWD_PC_IMM = 3'b011;
    localparam logic [RFWD_W-1:0] RFWD_PC_4   = 3'b100;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4
`ifdef ILLEGAL_INSTR_TRAP_EN
        , ST_HALT  = 3'd5
`endif
    } state_e;

    // exec_write: register file written in EXECUTE (loads write later, in WB)
    typedef struct packed {
        logic [ALU_W-1:0]  alu_ctrl;
        logic [RFWD_W-1:0] rfwd_sel;
        logic              alu_src;
        logic              jal;
        logic              jalr;
        logic              branch;
        logic              exec_write;
        logic              is_store;
        logic              is_load;
        logic              is_valid;
    } decode_t;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Instruction/bus handshake and datapath control strobes between the control FSM and datapath.
// ILLEGAL_INSTR_TRAP_EN adds the illegalInstr flag.
interface mc_control_fsm_if;

    logic [31:0] instrCode;
    logic        imemReady;
    logic        busReady;
    logic        irWe;
    logic        pcEn;
    logic        regFileWe;
    logic        aluSrcMuxSel;
    logic        busWe;
    logic        busRe;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        busTimeout;
    logic [3:0]  aluControl;
    logic [2:0]  RFWDSrcMuxSel;
`ifdef ILLEGAL_INSTR_TRAP_EN
    logic        illegalInstr;
`endif

    modport master (
        input  instrCode, imemReady, busReady,
        output irWe, pcEn, regFileWe, aluSrcMuxSel, busWe, busRe,
        output branch, jal, jalr, busTimeout, aluControl, RFWDSrcMuxSel
`ifdef ILLEGAL_INSTR_TRAP_EN
        , output illegalInstr
`endif
    );

    modport slave (
        output instrCode, imemReady, busReady,
        input  irWe, pcEn, regFileWe, aluSrcMuxSel, busWe, busRe,
        input  branch, jal, jalr, busTimeout, aluControl, RFWDSrcMuxSel
`ifdef ILLEGAL_INSTR_TRAP_EN
        , input illegalInstr
`endif
    );

endinterface

// File: rtl/instr_decoder.sv
// Static per-opcode decode for the multi-cycle RV32I controller (pure combinational).
module instr_decoder
    import rv32i_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7_b5,
    output decode_t          dec
);

    always_comb begin
        dec          = '0;
        dec.alu_ctrl = ALU_ADD;
        dec.rfwd_sel = RFWD_ALU;
        case (opcode)
            OPC_R: begin
                dec.alu_ctrl   = {funct7_b5, funct3};
                dec.exec_write = 1'b1;
                dec.is_valid   = 1'b1;
            end
            OPC_I: begin
                // bit 30 is immediate data for I-type except for the arithmetic right shift
                dec.alu_ctrl   = ({funct7_b5, funct3} == ALU_SRA) ? ALU_SRA : {1'b0, funct3};
                dec.alu_src    = 1'b1;
                dec.exec_write = 1'b1;
                dec.is_valid   = 1'b1;
            end
            OPC_LOAD: begin
                dec.alu_src  = 1'b1;
                dec.rfwd_sel = RFWD_MEM;
                dec.is_load  = 1'b1;
                dec.is_valid = 1'b1;
            end
            OPC_STORE: begin
                dec.alu_src  = 1'b1;
                dec.is_store = 1'b1;
                dec.is_valid = 1'b1;
            end
            OPC_BRANCH: begin
                dec.alu_ctrl = {funct7_b5, funct3};
                dec.branch   = 1'b1;
                dec.is_valid = 1'b1;
            end
            OPC_LUI: begin
                dec.rfwd_sel   = RFWD_IMM;
                dec.exec_write = 1'b1;
                dec.is_valid   = 1'b1;
            end
            OPC_AUIPC: begin
                dec.rfwd_sel   = RFWD_PC_IMM;
                dec.exec_write = 1'b1;
                dec.is_valid   = 1'b1;
            end
            OPC_JAL: begin
                dec.jal        = 1'b1;
                dec.rfwd_sel   = RFWD_PC_4;
                dec.exec_write = 1'b1;
                dec.is_valid   = 1'b1;
            end
            OPC_JALR: begin
                dec.jal        = 1'b1;
                dec.jalr       = 1'b1;
                dec.rfwd_sel   = RFWD_PC_4;
                dec.exec_write = 1'b1;
                dec.is_valid   = 1'b1;
            end
            default: dec = dec;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEM/WB with bus wait timeout.
// ILLEGAL_INSTR_TRAP_EN: unknown opcodes enter HALT (exit by reset only) and raise illegalInstr.
module mc_control_fsm
    import rv32i_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    mc_control_fsm_if.master     bus
);

    state_e              state;
    logic [WAIT_W-1:0]   wait_cnt;
    decode_t             dec;
    logic                wait_hit;
    logic                is_mem_op;

    logic                ir_we;
    logic                pc_en;
    logic                rf_we;
    logic                bus_we;
    logic                bus_re;
    logic                timeout;
    logic                show_static;
    logic                unused_instr_bits;

    instr_decoder u_decoder (
        .opcode    (bus.instrCode[6:0]),
        .funct3    (bus.instrCode[14:12]),
        .funct7_b5 (bus.instrCode[30]),
        .dec       (dec)
    );

    assign unused_instr_bits = ^{bus.instrCode[31], bus.instrCode[29:15],
                                 bus.instrCode[11:7], dec.is_valid};

    assign wait_hit  = (wait_cnt == WAIT_W'(MAX_WAIT));
    assign is_mem_op = dec.is_store | dec.is_load;

    // State and MEM wait counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_FETCH;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (bus.imemReady) state <= ST_DECODE;
                end
                ST_DECODE: begin
`ifdef ILLEGAL_INSTR_TRAP_EN
                    if (!dec.is_valid) state <= ST_HALT;
                    else               state <= ST_EXECUTE;
`else
                    state <= ST_EXECUTE;
`endif
                end
                ST_EXECUTE: begin
                    if (is_mem_op) begin
                        state    <= ST_MEM;
                        wait_cnt <= '0;
                    end else begin
                        state <= ST_FETCH;
                    end
                end
                ST_MEM: begin
                    if (bus.busReady)  state    <= dec.is_load ? ST_WB : ST_FETCH;
                    else if (wait_hit) state    <= ST_FETCH;
                    else               wait_cnt <= wait_cnt + WAIT_W'(1);
                end
                ST_WB:   state <= ST_FETCH;
`ifdef ILLEGAL_INSTR_TRAP_EN
                ST_HALT: state <= ST_HALT;
`endif
                default: state <= ST_FETCH;
            endcase
        end
    end

    // Strobes depend on busReady within the same MEM cycle, so they are decoded from state + inputs
    always_comb begin
        ir_we       = 1'b0;
        pc_en       = 1'b0;
        rf_we       = 1'b0;
        bus_we      = 1'b0;
        bus_re      = 1'b0;
        timeout     = 1'b0;
        show_static = 1'b0;
        if (!reset) begin
            case (state)
                ST_FETCH:  ir_we = 1'b1;
                ST_DECODE: show_static = 1'b1;
                ST_EXECUTE: begin
                    show_static = 1'b1;
                    pc_en       = !is_mem_op;
                    rf_we       = dec.exec_write;
                end
                ST_MEM: begin
                    show_static = 1'b1;
                    if (bus.busReady) begin
                        pc_en = dec.is_store;
                    end else if (wait_hit) begin
                        timeout = 1'b1;
                        pc_en   = 1'b1;
                    end
                    bus_we = dec.is_store & !timeout;
                    bus_re = dec.is_load & !timeout;
                end
                ST_WB: begin
                    show_static = 1'b1;
                    rf_we       = 1'b1;
                    pc_en       = 1'b1;
                end
                default: show_static = 1'b0;
            endcase
        end
    end

    assign bus.irWe          = ir_we;
    assign bus.pcEn          = pc_en;
    assign bus.regFileWe     = rf_we;
    assign bus.busWe         = bus_we;
    assign bus.busRe         = bus_re;
    assign bus.busTimeout    = timeout;
    assign bus.aluSrcMuxSel  = show_static & dec.alu_src;
    assign bus.branch        = show_static & dec.branch;
    assign bus.jal           = show_static & dec.jal;
    assign bus.jalr          = show_static & dec.jalr;
    assign bus.aluControl    = show_static ? dec.alu_ctrl : ALU_ADD;
    assign bus.RFWDSrcMuxSel = show_static ? dec.rfwd_sel : RFWD_ALU;
`ifdef ILLEGAL_INSTR_TRAP_EN
    assign bus.illegalInstr  = !reset && (state == ST_HALT);
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: per-cycle expected outputs queued with stimulus, checked each cycle.
// Honors ILLEGAL_INSTR_TRAP_EN for the unknown-opcode scenario.
module tb_mc_control_fsm;

    localparam int unsigned MAX_WAIT = 4;
`ifdef ILLEGAL_INSTR_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct packed {
        logic       ir_we;
        logic       pc_en;
        logic       rf_we;
        logic       alu_src;
        logic       bus_we;
        logic       bus_re;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       timeout;
        logic       illegal;
        logic [3:0] alu;
        logic [2:0] rfwd;
    } obs_t;

    typedef struct {
        logic [31:0] instr;
        logic        imem_ready;
        logic        bus_ready;
        logic        rst;
        obs_t        exp;
        string       tag;
    } step_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    step_t sb[$];

    always #5 clk = ~clk;

    mc_control_fsm_if bus ();

    mc_control_fsm #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic obs_t sample();
        obs_t o;
        o.ir_we   = bus.irWe;
        o.pc_en   = bus.pcEn;
        o.rf_we   = bus.regFileWe;
        o.alu_src = bus.aluSrcMuxSel;
        o.bus_we  = bus.busWe;
        o.bus_re  = bus.busRe;
        o.branch  = bus.branch;
        o.jal     = bus.jal;
        o.jalr    = bus.jalr;
        o.timeout = bus.busTimeout;
`ifdef ILLEGAL_INSTR_TRAP_EN
        o.illegal = bus.illegalInstr;
`else
        o.illegal = 1'b0;
`endif
        o.alu     = bus.aluControl;
        o.rfwd    = bus.RFWDSrcMuxSel;
        return o;
    endfunction

    task automatic push(input logic [31:0] instr, input logic imem, input logic busr,
                        input logic rst, input obs_t e, input string tag);
        step_t s;
        s.instr = instr; s.imem_ready = imem; s.bus_ready = busr;
        s.rst = rst; s.exp = e; s.tag = tag;
        sb.push_back(s);
    endtask

    // Reference model: per-cycle expected outputs for one instruction
    task automatic push_instr(input logic [31:0] instr, input int stall, input int waits,
                              input bit never, input int cut);
        obs_t st, e;
        int   kind;   // 0 exec+write, 1 exec no write, 2 store, 3 load, 4 unknown
        int   base;
        logic [2:0] f3;
        logic       b30;
        base = sb.size();
        f3   = instr[14:12];
        b30  = instr[30];
        st   = '0;
        kind = 4;
        case (instr[6:0])
            7'h33: begin st.alu = {b30, f3}; kind = 0; end
            7'h13: begin
                st.alu = (f3 == 3'd5) ? {b30, 3'd5} : {1'b0, f3};
                st.alu_src = 1'b1; kind = 0;
            end
            7'h03: begin st.alu_src = 1'b1; st.rfwd = 3'd1; kind = 3; end
            7'h23: begin st.alu_src = 1'b1; kind = 2; end
            7'h63: begin st.alu = {b30, f3}; st.branch = 1'b1; kind = 1; end
            7'h37: begin st.rfwd = 3'd2; kind = 0; end
            7'h17: begin st.rfwd = 3'd3; kind = 0; end
            7'h6F: begin st.jal = 1'b1; st.rfwd = 3'd4; kind = 0; end
            7'h67: begin st.jal = 1'b1; st.jalr = 1'b1; st.rfwd = 3'd4; kind = 0; end
            default: kind = 4;
        endcase

        e = '0; e.ir_we = 1'b1;
        for (int i = 0; i < stall; i++) push(instr, 1'b0, 1'b0, 1'b0, e, "fetch_stall");
        push(instr, 1'b1, 1'b0, 1'b0, e, "fetch");
        push(instr, 1'b0, 1'b0, 1'b0, st, "decode");

        if (kind == 4 && TRAP) begin
            e = '0; e.illegal = 1'b1;
            for (int i = 0; i < 3; i++) push(instr, 1'b1, 1'b1, 1'b0, e, "halt");
            e = '0;
            push(instr, 1'b0, 1'b0, 1'b1, e, "halt_reset");
        end else begin
            e = st;
            if (kind == 0 || kind == 1 || kind == 4) e.pc_en = 1'b1;
            e.rf_we = (kind == 0);
            push(instr, 1'b0, 1'b0, 1'b0, e, "execute");
            if (kind == 2 || kind == 3) begin
                e = st; e.bus_we = (kind == 2); e.bus_re = (kind == 3);
                if (never) begin
                    for (int k = 0; k < int'(MAX_WAIT); k++)
                        push(instr, 1'b0, 1'b0, 1'b0, e, "mem_wait");
                    e = st; e.timeout = 1'b1; e.pc_en = 1'b1;
                    push(instr, 1'b0, 1'b0, 1'b0, e, "mem_timeout");
                end else begin
                    for (int k = 0; k < waits; k++)
                        push(instr, 1'b0, 1'b0, 1'b0, e, "mem_wait");
                    e.pc_en = (kind == 2);
                    push(instr, 1'b0, 1'b1, 1'b0, e, "mem_ready");
                    if (kind == 3) begin
                        e = st; e.rf_we = 1'b1; e.pc_en = 1'b1;
                        push(instr, 1'b0, 1'b0, 1'b0, e, "wb");
                    end
                end
            end
        end
        if (cut >= 0)
            while (sb.size() > base + cut) sb.pop_back();
    endtask

    // Drive each queued cycle and compare outputs before the next rising edge
    task automatic drain();
        step_t s;
        obs_t  got;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge clk);
            bus.instrCode = s.instr;
            bus.imemReady = s.imem_ready;
            bus.busReady  = s.bus_ready;
            reset         = s.rst;
            #1;
            got = sample();
            checks++;
            if (got !== s.exp) begin
                errors++;
                $display("FAIL %s instr=%h: got %b expected %b", s.tag, s.instr, got, s.exp);
            end
        end
    endtask

    task automatic test_reset();
        obs_t z, f;
        z = '0; f = '0; f.ir_we = 1'b1;
        push(32'h002081B3, 1'b0, 1'b0, 1'b1, z, "reset");
        push(32'h002081B3, 1'b1, 1'b1, 1'b1, z, "reset_inputs_high");
        push(32'h002081B3, 1'b0, 1'b0, 1'b0, f, "post_reset_fetch");
        drain();
    endtask

    task automatic test_alu_ops();
        logic [31:0] tbl [11];
        tbl = '{32'h002081B3, 32'h40208133, 32'h4030D093, 32'h0030D093, 32'h40008093,
                32'h123450B7, 32'h00001097, 32'h008000EF, 32'h000080E7, 32'h00208463,
                32'h40209463};
        foreach (tbl[i]) push_instr(tbl[i], i % 2, 0, 1'b0, -1);
        drain();
    endtask

    task automatic test_load();
        push_instr(32'h0000A183, 0, 0, 1'b0, -1);
        push_instr(32'h0000A183, 0, 2, 1'b0, -1);
        drain();
    endtask

    task automatic test_store();
        push_instr(32'h0020A023, 0, 0, 1'b0, -1);
        push_instr(32'h0020A023, 1, 1, 1'b0, -1);
        drain();
    endtask

    task automatic test_timeout();
        push_instr(32'h0020A023, 0, 0, 1'b1, -1);
        push_instr(32'h0000A183, 0, 0, 1'b1, -1);
        drain();
    endtask

    task automatic test_ready_wins();
        push_instr(32'h0020A023, 0, int'(MAX_WAIT), 1'b0, -1);
        push_instr(32'h0000A183, 0, int'(MAX_WAIT), 1'b0, -1);
        drain();
    endtask

    task automatic test_reset_mid_mem();
        obs_t z, f;
        z = '0; f = '0; f.ir_we = 1'b1;
        push_instr(32'h0000A183, 0, 0, 1'b1, 5);   // fetch, decode, execute, two MEM waits
        push(32'h0000A183, 1'b0, 1'b1, 1'b1, z, "reset_in_mem");
        push(32'h0000A183, 1'b0, 1'b0, 1'b0, f, "fetch_after_abort");
        push_instr(32'h002081B3, 0, 0, 1'b0, -1);
        drain();
    endtask

    task automatic test_illegal();
        obs_t f;
        f = '0; f.ir_we = 1'b1;
        push_instr(32'h0000007F, 0, 0, 1'b0, -1);
        push(32'h0000007F, 1'b0, 1'b0, 1'b0, f, "fetch_after_illegal");
        drain();
    endtask

    task automatic test_back_to_back();
        push_instr(32'h002081B3, 0, 0, 1'b0, -1);
        push_instr(32'h0000A183, 1, 1, 1'b0, -1);
        push_instr(32'h0020A023, 0, 0, 1'b0, -1);
        push_instr(32'h00208463, 2, 0, 1'b0, -1);
        push_instr(32'h008000EF, 0, 0, 1'b0, -1);
        drain();
    endtask

    initial begin
        reset         = 1'b1;
        bus.instrCode = 32'h0;
        bus.imemReady = 1'b0;
        bus.busReady  = 1'b0;
        test_reset();
        test_alu_ops();
        test_load();
        test_store();
        test_timeout();
        test_ready_wins();
        test_reset_mid_mem();
        test_illegal();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
